apb_slave_regs: RTL and testbench

APB_SLAVE_REGS -- requirements
Module: apb_slave_regs

---
 rtl/apb_pkg.sv | 27 ++
 rtl/apb_wait_cnt.sv | 28 ++
 rtl/apb_slave_regs.sv | 161 ++++++++++++++++
 tb/tb_apb_slave_regs.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB register slave.
// Holds the FSM state enum and the legal data-width constants.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int unsigned DW_8  = 8;
  localparam int unsigned DW_16 = 16;
  localparam int unsigned DW_32 = 32;

  // Number of byte-offset address bits for a given data width.
  function automatic int unsigned lane_bits(
    input int unsigned dw
  );
    int unsigned lb;
    lb = 2;
    if (dw == DW_8) lb = 0;
    else if (dw == DW_16) lb = 1;
    else if (dw == DW_32) lb = 2;
    return lb;
  endfunction

endpackage

// File: rtl/apb_wait_cnt.sv
// Loadable down-counter for APB access wait states.
// Ports: clock, reset_n, load, dec, load_val[W], zero (count == 0).
module apb_wait_cnt #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/apb_slave_regs.sv
// APB register-file slave with configurable wait states.
// Ports: clock, reset_n, sel, enable, write, addr, wdata -> rdata, ready,
// slverr, regs_q (flattened). Macro APB_SLVERR_EN enables slverr.
module apb_slave_regs
  import apb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_REGS    = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       sel,
  input  logic                       enable,
  input  logic                       write,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata,
  output logic                       ready,
  output logic                       slverr,
  output logic [NUM_REGS*DATA_W-1:0] regs_q
);

  localparam int LB = int'(lane_bits(DATA_W));
  localparam int CW =
    (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);

  apb_state_e state_q, state_d;

  logic              cap;
  logic              ready_i;
  logic              cnt_zero;
  logic              commit;
  logic              wr_q;
  logic              bad_q;
  logic [ADDR_W-1:0] idx_q;
  logic [DATA_W-1:0] wd_q;
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] rd_sel;
  logic [DATA_W-1:0] rd_val;
  logic [ADDR_W-1:0] idx;
  logic              in_rng;
  logic              mis;

  logic [DATA_W-1:0] mem [NUM_REGS];

  assign idx    = addr >> LB;
  assign in_rng =
    ({1'b0, idx} < (ADDR_W+1)'(NUM_REGS));

  if (LB > 0) begin : g_mis
    assign mis = |addr[LB-1:0];
  end else begin : g_nomis
    assign mis = 1'b0;
  end

  apb_wait_cnt #(
    .W (CW)
  ) u_wait (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (state_q == SETUP),
    .dec      (state_q == ACCESS),
    .load_val (CW'(WAIT_STATES)),
    .zero     (cnt_zero)
  );

  assign ready_i = (state_q == ACCESS) && cnt_zero;
  assign commit  = ready_i && wr_q && !bad_q;

  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // enable without a prior setup phase is ignored
        if (sel && !enable) begin
          state_d = SETUP;
          cap     = 1'b1;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (ready_i) begin
          if (sel && !enable) begin
            state_d = SETUP;
            cap     = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (!sel) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx_q == ADDR_W'(i)) rd_sel = mem[i];
    end
    rd_val = bad_q ? '0 : rd_sel;
  end

  // The request is latched at setup because the
  // bus may already carry the next setup phase
  // during our ready cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      bad_q   <= 1'b0;
      idx_q   <= '0;
      wd_q    <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      if (cap) begin
        wr_q  <= write;
        idx_q <= idx;
        bad_q <= mis | !in_rng;
        wd_q  <= wdata;
      end
      if (ready_i) hold_q <= rd_val;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (commit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (idx_q == ADDR_W'(i)) mem[i] <= wd_q;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_q[g*DATA_W +: DATA_W] = mem[g];
  end

  // Outputs come only from registered state.
  assign ready = ready_i;
  assign rdata = ready_i ? rd_val : hold_q;

`ifdef APB_SLVERR_EN
  assign slverr = ready_i & bad_q;
`else
  assign slverr = 1'b0;
`endif

endmodule

// File: tb/tb_apb_slave_regs.sv
// Self-checking bench for apb_slave_regs.
// Directed table, corner sequences and randomized traffic vs a model.
module tb_apb_slave_regs;
  import apb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 8;
  localparam int WS = 3;
  localparam int FW = NR * DW;

`ifdef APB_SLVERR_EN
  localparam bit SLV = 1'b1;
`else
  localparam bit SLV = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset_n;
  logic          sel;
  logic          enable;
  logic          write;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ready;
  logic          slverr;
  logic [FW-1:0] regs_q;

  always #5 clock = ~clock;

  apb_slave_regs #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .NUM_REGS    (NR),
    .WAIT_STATES (WS)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .sel     (sel),
    .enable  (enable),
    .write   (write),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .ready   (ready),
    .slverr  (slverr),
    .regs_q  (regs_q)
  );

  int passed = 0;
  int total  = 0;

  logic [DW-1:0] mdl [NR];
  logic [DW-1:0] last_rd;

  typedef struct {
    bit            w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] er;
    bit            inv;
    bit            b2b;
  } vec_t;

  vec_t tbl [12];

  task automatic check(
    input string nm,
    input logic [FW-1:0] got,
    input logic [FW-1:0] exp
  );
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h want %h",
                  nm, got, exp);
  endtask

  function automatic bit mvalid(
    input logic [AW-1:0] a
  );
    return (a % 4 == 0) && (a / 4 < NR);
  endfunction

  function automatic logic [FW-1:0] mflat();
    logic [FW-1:0] r;
    for (int i = 0; i < NR; i++)
      r[i*DW +: DW] = mdl[i];
    return r;
  endfunction

  task automatic setup_drive(
    input bit w,
    input logic [AW-1:0] a,
    input logic [DW-1:0] d
  );
    sel    = 1'b1;
    enable = 1'b0;
    write  = w;
    addr   = a;
    wdata  = d;
  endtask

  // Runs from the setup phase up to the negedge
  // of the ready cycle (or a timeout).
  task automatic run_xfer(
    input string nm,
    input bit w,
    input logic [AW-1:0] a,
    input logic [DW-1:0] d,
    input logic [DW-1:0] er,
    input bit inv
  );
    int n;
    bit got;
    @(posedge clock);
    @(negedge clock);
    check({nm, " setup-ready"}, ready, 0);
    enable = 1'b1;
    n = 0;
    got = 1'b0;
    while (n < WS + 4 && !got) begin
      @(posedge clock);
      @(negedge clock);
      n++;
      if (ready) got = 1'b1;
    end
    check({nm, " latency"}, got ? n : 0, WS + 1);
    if (got) begin
      check({nm, " rdata"}, rdata, er);
      check({nm, " slverr"}, slverr, SLV & inv);
    end
    if (w && !inv) mdl[a / 4] = d;
    last_rd = er;
  endtask

  task automatic idle_check(input string nm);
    sel    = 1'b0;
    enable = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check({nm, " idle-ready"}, ready, 0);
    check({nm, " regs"}, regs_q, mflat());
    check({nm, " hold"}, rdata, last_rd);
  endtask

  bit            cw, nw;
  logic [AW-1:0] ca, na;
  logic [DW-1:0] cd, nd;
  logic [DW-1:0] cer;
  bit            cinv;
  bit            chained;

  task automatic gen_txn(
    output bit w,
    output logic [AW-1:0] a,
    output logic [DW-1:0] d
  );
    w = 1'($urandom_range(0, 1));
    a = AW'($urandom_range(0, 79));
    if ($urandom_range(0, 3) != 0) a = a & ~AW'(3);
    d = $urandom;
  endtask

  initial begin
    tbl[0]  = '{1, 32'h04, 32'hDEADBEEF, 0, 0, 0};
    tbl[1]  = '{0, 32'h04, 0, 32'hDEADBEEF, 0, 0};
    tbl[2]  = '{1, 32'h40, 32'h55, 0, 1, 1};
    tbl[3]  = '{0, 32'h40, 0, 0, 1, 0};
    tbl[4]  = '{1, 32'h06, 32'h77, 0, 1, 0};
    tbl[5]  = '{0, 32'h04, 0, 32'hDEADBEEF, 0, 0};
    tbl[6]  = '{1, 32'h00, 32'h11, 0, 0, 1};
    tbl[7]  = '{0, 32'h00, 0, 32'h11, 0, 0};
    tbl[8]  = '{1, 32'h1C, 32'h12345678, 0, 0, 0};
    tbl[9]  = '{1, 32'h1C, 32'hA5A5A5A5,
                32'h12345678, 0, 1};
    tbl[10] = '{0, 32'h1C, 0, 32'hA5A5A5A5, 0, 0};
    tbl[11] = '{0, 32'h3C, 0, 0, 1, 0};

    for (int i = 0; i < NR; i++) mdl[i] = '0;
    last_rd = '0;
    reset_n = 1'b0;
    sel     = 1'b0;
    enable  = 1'b0;
    write   = 1'b0;
    addr    = '0;
    wdata   = '0;

    #1;
    check("rst ready", ready, 0);
    check("rst slverr", slverr, 0);
    check("rst rdata", rdata, 0);
    check("rst regs", regs_q, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    // enable alone in idle must not start a transfer
    enable = 1'b1;
    repeat (3) @(negedge clock);
    check("stray enable ready", ready, 0);
    enable = 1'b0;

    for (int i = 0; i < 12; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      if (i == 0 || !tbl[i-1].b2b)
        setup_drive(tbl[i].w, tbl[i].a, tbl[i].d);
      run_xfer(nm, tbl[i].w, tbl[i].a, tbl[i].d,
               tbl[i].er, tbl[i].inv);
      if (tbl[i].b2b && i < 11)
        setup_drive(tbl[i+1].w, tbl[i+1].a,
                    tbl[i+1].d);
      else
        idle_check(nm);
    end

    // abort: sel dropped in 2nd access cycle
    setup_drive(1, 32'h08, 32'hCAFEF00D);
    @(posedge clock);
    @(negedge clock);
    enable = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("abort c1 ready", ready, 0);
    @(posedge clock);
    @(negedge clock);
    check("abort c2 ready", ready, 0);
    sel    = 1'b0;
    enable = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("abort state", dut.state_q == IDLE, 1);
    for (int k = 0; k < 4; k++) begin
      check("abort ready", ready, 0);
      @(negedge clock);
    end
    check("abort regs", regs_q, mflat());
    check("abort hold", rdata, last_rd);
    setup_drive(0, 32'h08, 0);
    run_xfer("abort rd", 0, 32'h08, 0, mdl[2], 0);
    idle_check("abort rd");

    // reset during the access phase of a write
    setup_drive(1, 32'h10, 32'h0000BEEF);
    @(posedge clock);
    @(negedge clock);
    enable = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    sel     = 1'b0;
    enable  = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    last_rd = '0;
    check("mid-rst ready", ready, 0);
    check("mid-rst regs", regs_q, 0);
    check("mid-rst rdata", rdata, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("post-rst regs", regs_q, 0);
    setup_drive(1, 32'h10, 32'h0000BEEF);
    run_xfer("post-rst wr", 1, 32'h10,
             32'h0000BEEF, 0, 0);
    idle_check("post-rst wr");

    // randomized traffic against the model
    chained = 1'b0;
    gen_txn(cw, ca, cd);
    for (int k = 0; k < 40; k++) begin
      cinv = !mvalid(ca);
      cer  = cinv ? '0 : mdl[ca / 4];
      if (!chained) setup_drive(cw, ca, cd);
      run_xfer($sformatf("rnd%0d", k),
               cw, ca, cd, cer, cinv);
      gen_txn(nw, na, nd);
      chained = (k < 39) &&
                ($urandom_range(0, 1) == 1);
      if (chained) setup_drive(nw, na, nd);
      else idle_check($sformatf("rnd%0d", k));
      cw = nw;
      ca = na;
      cd = nd;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
